// File: rtl/complex_mult_pkg.sv
// Shared types and helpers for the pipelined complex multiplier.
// round_sat works on a wide signed container so any legal parameter set fits.
package complex_mult_pkg;

    // Wide enough for FULL_W+1 with IN_W up to 64.
    localparam int MAX_W = 130;

    typedef struct packed {
        logic                    ovf;
        logic signed [MAX_W-1:0] value;
    } rs_t;

    function automatic int full_w(input int in_w);
        return 2 * in_w + 1;
    endfunction

    function automatic rs_t round_sat(input logic signed [MAX_W-1:0] value,
                                      input int                      shift,
                                      input logic                    round,
                                      input logic                    sat,
                                      input int                      out_w);
        logic signed [MAX_W-1:0] one;
        logic signed [MAX_W-1:0] sum;
        logic signed [MAX_W-1:0] scaled;
        logic signed [MAX_W-1:0] max_v;
        logic signed [MAX_W-1:0] min_v;
        logic signed [MAX_W-1:0] shl;
        rs_t                     r;
        one = {{(MAX_W-1){1'b0}}, 1'b1};
        sum = value;
        if (round && shift > 0)
            sum = value + (one << (shift - 1));
        scaled = sum >>> shift;
        max_v  = (one << (out_w - 1)) - one;
        min_v  = -(one << (out_w - 1));
        // Shifting up then arithmetically back keeps the low out_w bits, sign-extended.
        shl    = scaled <<< (MAX_W - out_w);
        r.ovf  = (scaled > max_v) || (scaled < min_v);
        if (r.ovf && sat)
            r.value = (scaled > max_v) ? max_v : min_v;
        else
            r.value = shl >>> (MAX_W - out_w);
        return r;
    endfunction

endpackage

// File: rtl/complex_mult_pipe_round_sat.sv
// Output scaling for one result component: optional round half-up,
// arithmetic shift, then saturate or wrap into OUT_W bits.
module round_sat
    import complex_mult_pkg::*;
#(
    parameter int VAL_W = 33,
    parameter int OUT_W = 33,
    parameter int SHIFT = 0,
    parameter int ROUND = 0,
    parameter int SAT   = 1
) (
    input  logic signed [VAL_W-1:0] value,
    output logic signed [OUT_W-1:0] result,
    output logic                    ovf
);

    rs_t  rs;
    logic unused_hi;

    always_comb begin
        rs = complex_mult_pkg::round_sat(MAX_W'(value), SHIFT, ROUND != 0, SAT != 0, OUT_W);
    end

    assign result    = rs.value[OUT_W-1:0];
    assign ovf       = rs.ovf;
    assign unused_hi = ^rs.value[MAX_W-1:OUT_W];

endmodule

// File: rtl/complex_mult_pipe.sv
// Three-stage pipelined complex multiplier (operands, products, add/scale)
// with optional conj(y) and a valid/ready stream on both sides.
module complex_mult_pipe
    import complex_mult_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 33,
    parameter int SHIFT = 0,
    parameter int ROUND = 0,
    parameter int SAT   = 1
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  re_x,
    input  logic signed [IN_W-1:0]  im_x,
    input  logic signed [IN_W-1:0]  re_y,
    input  logic signed [IN_W-1:0]  im_y,
    input  logic                    conj_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] re_z,
    output logic signed [OUT_W-1:0] im_z,
    output logic                    ovf
);

    localparam int FULL_W = full_w(IN_W);

    typedef struct packed {
        logic signed [IN_W-1:0] re;
        logic signed [IN_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [FULL_W-1:0] rr;
        logic signed [FULL_W-1:0] ii;
        logic signed [FULL_W-1:0] ir;
        logic signed [FULL_W-1:0] ri;
    } prod_t;

    // Handshake: a sample transfers on any edge where valid && ready are both high.
    // The whole pipeline advances together; it freezes only when a result is
    // waiting and downstream is not ready, so accept and consume may coincide.
    logic en;

    cplx_t s1_x;
    cplx_t s1_y;
    logic  s1_conj;
    logic  s1_valid;

    prod_t s2_p;
    logic  s2_conj;
    logic  s2_valid;

    logic signed [FULL_W-1:0] re_full;
    logic signed [FULL_W-1:0] im_full;
    logic signed [OUT_W-1:0]  re_q;
    logic signed [OUT_W-1:0]  im_q;
    logic                     ovf_re;
    logic                     ovf_im;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        re_full = s2_p.rr - s2_p.ii;
        im_full = s2_p.ir + s2_p.ri;
        if (s2_conj) begin
            re_full = s2_p.rr + s2_p.ii;
            im_full = s2_p.ir - s2_p.ri;
        end
    end

    round_sat #(
        .VAL_W(FULL_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .ROUND(ROUND), .SAT(SAT)
    ) u_rs_re (
        .value(re_full), .result(re_q), .ovf(ovf_re)
    );

    round_sat #(
        .VAL_W(FULL_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .ROUND(ROUND), .SAT(SAT)
    ) u_rs_im (
        .value(im_full), .result(im_q), .ovf(ovf_im)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_x      <= '0;
            s1_y      <= '0;
            s1_conj   <= 1'b0;
            s1_valid  <= 1'b0;
            s2_p      <= '0;
            s2_conj   <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            re_z      <= '0;
            im_z      <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x.re <= re_x;
                s1_x.im <= im_x;
                s1_y.re <= re_y;
                s1_y.im <= im_y;
                s1_conj <= conj_y;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_p.rr <= FULL_W'($signed(s1_x.re)) * FULL_W'($signed(s1_y.re));
                s2_p.ii <= FULL_W'($signed(s1_x.im)) * FULL_W'($signed(s1_y.im));
                s2_p.ir <= FULL_W'($signed(s1_x.im)) * FULL_W'($signed(s1_y.re));
                s2_p.ri <= FULL_W'($signed(s1_x.re)) * FULL_W'($signed(s1_y.im));
                s2_conj <= s1_conj;
            end
            out_valid <= s2_valid;
            ovf       <= s2_valid && (ovf_re || ovf_im);
            if (s2_valid) begin
                re_z <= re_q;
                im_z <= im_q;
            end
        end
    end

endmodule
